// File: rtl/mem_bus_arbiter_if.sv
// Shared memory-port bundle between the two cache miss ports, the arbiter and memory.
// The slave side is the arbiter. The master side is the cache/memory environment.
interface mem_bus_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [1:0]       icache2mem_command;
    logic [XLEN-1:0]  icache2mem_addr;
    logic [1:0]       dcache2mem_command;
    logic [XLEN-1:0]  dcache2mem_addr;
    logic [63:0]      dcache2mem_data;
    logic [1:0]       proc2mem_command;
    logic [XLEN-1:0]  proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [TAG_W-1:0] mem2proc_response;
    logic [63:0]      mem2proc_data;
    logic [TAG_W-1:0] mem2proc_tag;
    logic [TAG_W-1:0] mem2icache_response;
    logic [TAG_W-1:0] mem2dcache_response;
    logic [63:0]      mem2cache_data;
    logic [TAG_W-1:0] mem2icache_tag;
    logic [TAG_W-1:0] mem2dcache_tag;
    logic [1:0]       gnt_debug;
    logic             err_unowned;

    modport slave (
        input  icache2mem_command, icache2mem_addr,
        input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2icache_response, mem2dcache_response,
        output mem2cache_data, mem2icache_tag, mem2dcache_tag,
        output gnt_debug, err_unowned
    );

    modport master (
        output icache2mem_command, icache2mem_addr,
        output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2icache_response, mem2dcache_response,
        input  mem2cache_data, mem2icache_tag, mem2dcache_tag,
        input  gnt_debug, err_unowned
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between icache and dcache and routes
// returning load tags back to whichever cache issued them.
module mem_bus_arbiter #(
    parameter int DCACHE_FIXED_PRIO = 0,
    parameter int TAG_W             = 4,
    parameter int XLEN              = 32
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam int         NTAG     = 1 << TAG_W;

    typedef enum logic {S_IDLE, S_HOLD} state_e;

    state_e            r_state;
    logic              r_hold_id;
    logic              r_last_gnt;
    logic              r_err;
    logic [NTAG-1:0]   r_own_v;
    logic [NTAG-1:0]   r_own_d;

    logic              w_ireq;
    logic              w_dreq;
    logic              w_held_req;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_gnt_any;
    logic              w_acc;
    logic [1:0]        w_cmd;
    logic [TAG_W-1:0]  w_resp;
    logic [TAG_W-1:0]  w_tag;
    logic              w_ret_hit;
    logic              w_ret_d;

    assign w_ireq     = bus.icache2mem_command != BUS_NONE;
    assign w_dreq     = bus.dcache2mem_command != BUS_NONE;
    assign w_held_req = r_hold_id ? w_dreq : w_ireq;
    assign w_resp     = bus.mem2proc_response;
    assign w_tag      = bus.mem2proc_tag;

    // Grant must be combinational: memory accepts or refuses in the same cycle.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (!reset) begin
            if (r_state == S_HOLD && w_held_req) begin
                w_gnt_d = r_hold_id;
                w_gnt_i = !r_hold_id;
            end else if (w_ireq && !w_dreq) begin
                w_gnt_i = 1'b1;
            end else if (w_dreq && !w_ireq) begin
                w_gnt_d = 1'b1;
            end else if (w_ireq && w_dreq) begin
                w_gnt_d = (DCACHE_FIXED_PRIO != 0) || !r_last_gnt;
                w_gnt_i = !w_gnt_d;
            end
        end
    end

    assign w_gnt_any = w_gnt_i | w_gnt_d;
    assign w_acc     = w_gnt_any && (w_resp != '0);

    always_comb begin
        w_cmd             = BUS_NONE;
        bus.proc2mem_addr = '0;
        bus.proc2mem_data = '0;
        if (w_gnt_i) begin
            w_cmd             = bus.icache2mem_command;
            bus.proc2mem_addr = bus.icache2mem_addr;
        end else if (w_gnt_d) begin
            w_cmd             = bus.dcache2mem_command;
            bus.proc2mem_addr = bus.dcache2mem_addr;
            bus.proc2mem_data = bus.dcache2mem_data;
        end
    end

    assign bus.proc2mem_command    = w_cmd;
    assign bus.mem2icache_response = w_gnt_i ? w_resp : '0;
    assign bus.mem2dcache_response = w_gnt_d ? w_resp : '0;
    assign bus.mem2cache_data      = bus.mem2proc_data;
    assign bus.gnt_debug           = {w_gnt_d, w_gnt_i};
    assign bus.err_unowned         = r_err;

    assign w_ret_hit = !reset && (w_tag != '0) && r_own_v[w_tag];
    assign w_ret_d   = r_own_d[w_tag];

    assign bus.mem2icache_tag = (w_ret_hit && !w_ret_d) ? w_tag : '0;
    assign bus.mem2dcache_tag = (w_ret_hit &&  w_ret_d) ? w_tag : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold_id  <= 1'b0;
            r_last_gnt <= 1'b1;
            r_err      <= 1'b0;
            r_own_v    <= '0;
            r_own_d    <= '0;
        end else begin
            if (w_acc)
                r_last_gnt <= w_gnt_d;
            case (r_state)
                S_IDLE:
                    if (w_gnt_any && w_resp == '0) begin
                        r_state   <= S_HOLD;
                        r_hold_id <= w_gnt_d;
                    end
                S_HOLD:
                    if (!w_held_req || w_acc)
                        r_state <= S_IDLE;
            endcase
            if (w_tag != '0) begin
                if (r_own_v[w_tag])
                    r_own_v[w_tag] <= 1'b0;
                else
                    r_err <= 1'b1;
            end
            // A new allocation overrides a same-cycle return of that tag.
            if (w_acc && w_cmd == BUS_LOAD) begin
                r_own_v[w_resp] <= 1'b1;
                r_own_d[w_resp] <= w_gnt_d;
            end
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port (`proc2mem_*` / `mem2proc_*`) between the icache and the dcache.
- Grants at most one requester per cycle and passes that requester's command, address and data to memory.
- Routes the memory's same-cycle response only to the granted requester.
- Tracks which requester owns each outstanding load tag, so returning data is delivered to the correct cache.
- Sits between the icache/dcache miss ports and the `mem` module.

Parameters:
- DCACHE_FIXED_PRIO, 0: 0 = round-robin between requesters; 1 = dcache always wins when both request.
- TAG_W, 4: width of memory transaction tags; tag 0 means "none".

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- icache2mem_command  input  2  icache bus command (BUS_NONE/BUS_LOAD/BUS_STORE)
- icache2mem_addr  input  XLEN  icache address
- dcache2mem_command  input  2  dcache bus command
- dcache2mem_addr  input  XLEN  dcache address
- dcache2mem_data  input  64  dcache store data
- proc2mem_command  output  2  command to memory
- proc2mem_addr  output  XLEN  address to memory
- proc2mem_data  output  64  store data to memory
- mem2proc_response  input  TAG_W  memory accept tag (0 = not accepted)
- mem2proc_data  input  64  returning load data
- mem2proc_tag  input  TAG_W  tag of returning data (0 = none)
- mem2icache_response  output  TAG_W  response routed to icache
- mem2dcache_response  output  TAG_W  response routed to dcache
- mem2cache_data  output  64  `mem2proc_data` broadcast to both caches
- mem2icache_tag  output  TAG_W  returning tag if icache owns it, else 0
- mem2dcache_tag  output  TAG_W  returning tag if dcache owns it, else 0
- gnt_debug  output  2  one-hot current grant {dcache, icache}
- err_unowned  output  1  sticky: a tag returned with no recorded owner

Behaviour:
- Request: a requester is requesting when its command != BUS_NONE.
- Grant is combinational from the current requests plus registered state, because memory replies in the same cycle.
- Grant priority, evaluated in order:
  1. Hold: if `hold_valid`, grant the held requester while it still requests.
  2. Single requester: grant it.
  3. Both requesting: if DCACHE_FIXED_PRIO = 1, grant dcache; otherwise grant the requester not in `last_gnt`.
  4. No request: no grant.
- Drive to memory:
  - Granted requester's command and address are driven to memory.
  - `proc2mem_data` = `dcache2mem_data` when dcache is granted, else 0.
  - No grant: command = BUS_NONE, address = 0, data = 0.
- Response routing:
  - The granted requester's `*_response` = `mem2proc_response`.
  - The non-granted requester's `*_response` = 0.
  - A non-granted requester's command is never forwarded.
- Registered state:
  - `last_gnt` (1 bit): updated on every accepted transaction (response != 0) to the requester accepted.
  - `hold_valid` / `hold_id` FSM:
    - IDLE -> HOLD when a granted command gets response = 0; `hold_id` = that requester.
    - HOLD -> IDLE when the held requester's command is accepted, or it drops its request (command = BUS_NONE).
    - While in HOLD, the other requester is stalled: it receives response 0.
- Ownership table: 2^TAG_W entries of {valid, owner}; entry 0 is unused.
  - Set: accepted BUS_LOAD with response = t sets entry t = {1, granted id}.
  - Stores: accepted BUS_STORE does not allocate an entry; stores have no data return.
  - Return: when `mem2proc_tag` = t != 0 and entry t is valid, drive t on the owner's `*_tag` output (other output 0), then clear entry t at the clock edge.
  - Same-cycle set and return of the same tag t: the return consumes the old entry, and the new allocation wins the write, so entry t stays valid with the new owner.
  - Unowned return: `mem2proc_tag` != 0 with entry invalid → both `*_tag` outputs 0, data dropped, `err_unowned` set until reset.
- Reset (synchronous, any cycle):
  - Clears the ownership table, `hold_valid` and `err_unowned`; `last_gnt` = dcache, so icache wins the first tie under round-robin.
  - Outputs in the reset cycle: `proc2mem_command` = BUS_NONE, address 0, data 0; all `*_response` and `*_tag` = 0; `gnt_debug` = 0.
  - Tags still in flight from before reset return as unowned: they set `err_unowned`, by design.
- Latency: zero-cycle command path and zero-cycle tag routing (both combinational); state updates at the next posedge.

Test Plan:
- Icache only: icache LOAD addr 0x0 with memory response 3, later `mem2proc_tag` = 3 → `mem2icache_response` = 3, `mem2dcache_response` = 0, `mem2icache_tag` = 3, `mem2dcache_tag` = 0, entry 3 cleared.
- Round-robin tie, DCACHE_FIXED_PRIO = 0, both requesting every cycle, memory always accepting → grants alternate I, D, I, D starting with icache after reset; `gnt_debug` = 01, 10, 01, 10.
- Hold: dcache LOAD gets response 0 for 3 cycles while icache also requests → dcache keeps the grant all 4 cycles; icache response 0 throughout; icache is granted in the cycle after dcache is accepted.
- Interleaved returns: icache gets tag 5 and dcache gets tag 6; memory returns 6, then 5 → `mem2dcache_tag` = 6, then `mem2icache_tag` = 5; the other tag output stays 0 in each cycle.
- Store: dcache STORE accepted with tag 7, then `mem2proc_tag` = 7 → no routing (both tag outputs 0), `err_unowned` = 1.
- Reset mid-flight: icache load tag 2 outstanding, reset asserted for 1 cycle, then tag 2 returns → `mem2icache_tag` = 0, `err_unowned` = 1; first post-reset tie is granted to icache.
